// File: rtl/mem_access_pkg.sv
// Shared types for the MEM-stage data-memory access unit: access size codes,
// the access FSM state encoding and a size-to-byte-count helper.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Number of bytes touched by an access of the given size code.
  function automatic int unsigned nbytes_of(input logic [1:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load-data formatter: moves the addressed lane down to bit 0, keeps the
// access width and sign- or zero-extends it to the full bus width.
module load_extend
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]             rdata,
  input  logic [$clog2(DATA_W/8)-1:0]   lane,
  input  logic [1:0]                    size,
  input  logic                          is_unsigned,
  output logic [DATA_W-1:0]             ext_data
);

  logic [DATA_W-1:0] shifted;
  int unsigned       nbits;
  logic              sign;

  // Lane extraction followed by width truncation and extension.
  always_comb begin
    shifted = rdata >> (32'(lane) * 32'd8);
    nbits   = nbytes_of(size) * 32'd8;
    // A dword code on a 32-bit bus never reaches here as a real load; clamp
    // so the sign-bit index stays inside the bus.
    if (nbits > DATA_W) nbits = DATA_W;
    sign = is_unsigned ? 1'b0 : shifted[nbits-1];
    for (int unsigned i = 0; i < DATA_W; i++) begin
      ext_data[i] = (i < nbits) ? shifted[i] : sign;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit. Takes one load/store at a time over a
// valid/ready handshake, drives a handshaked memory port with byte enables and
// lane-replicated store data, and returns extended load data or an exception.
// Optional feature macro: MEM_ACCESS_ALIGN_EXC_EN -- misaligned addresses fault
// instead of being silently aligned down.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_exc
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned LW = $clog2(NB);

  state_e state_q, state_d;

  logic                accept;
  logic                size_bad;
  logic                fault;
  int unsigned         acc_nb;
  logic [LW-1:0]       in_lane;
  logic [LW-1:0]       acc_lane;
  logic [NB-1:0]       acc_be;
  logic [DATA_W-1:0]   acc_wdata;
  logic [ADDR_W-1:0]   acc_addr;
`ifdef MEM_ACCESS_ALIGN_EXC_EN
  logic                misalign;
`endif

  logic                mem_we_q;
  logic [NB-1:0]       be_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [LW-1:0]       lane_q;
  logic                exc_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   ext_data;

  // Decode the incoming request into memory-port fields and a fault flag.
  always_comb begin
    accept   = req_valid && (state_q == ST_IDLE);
    acc_nb   = nbytes_of(req_size);
    if (acc_nb > NB) acc_nb = NB;
    size_bad = (NB == 32'd4) && (req_size == SZ_D);
    in_lane  = req_addr[LW-1:0];
`ifdef MEM_ACCESS_ALIGN_EXC_EN
    misalign = (32'(in_lane) & (acc_nb - 32'd1)) != 32'd0;
    acc_lane = in_lane;
    fault    = size_bad || misalign;
`else
    // Drop the sub-size address bits so the access is naturally aligned.
    acc_lane = LW'(32'(in_lane) & ~(acc_nb - 32'd1));
    fault    = size_bad;
`endif
    for (int unsigned i = 0; i < NB; i++) begin
      acc_be[i] = (i >= 32'(acc_lane)) && (i < 32'(acc_lane) + acc_nb);
      acc_wdata[8*i +: 8] = req_wdata[8*(i & (acc_nb - 32'd1)) +: 8];
    end
    acc_addr = {req_addr[ADDR_W-1:LW], {LW{1'b0}}};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)     state_d = fault ? ST_RESP : ST_REQ;
      ST_REQ:  if (mem_ready)  state_d = mem_we_q ? ST_RESP : ST_WAIT;
      ST_WAIT: if (mem_rvalid) state_d = ST_RESP;
      ST_RESP:                 state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    req_ready = 1'b0;
    mem_valid = 1'b0;
    rsp_valid = 1'b0;
    rsp_exc   = 1'b0;
    unique case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_REQ:  mem_valid = 1'b1;
      ST_WAIT: ;
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_exc   = exc_q;
      end
      default: ;
    endcase
  end

  // Request capture on accept; load data capture on the read-data beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we_q <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      lane_q   <= '0;
      exc_q    <= 1'b0;
      data_q   <= '0;
    end else if (accept) begin
      mem_we_q <= req_we;
      be_q     <= acc_be;
      addr_q   <= acc_addr;
      wdata_q  <= acc_wdata;
      size_q   <= req_size;
      uns_q    <= req_unsigned;
      lane_q   <= acc_lane;
      exc_q    <= fault;
      data_q   <= '0;
    end else if (state_q == ST_WAIT && mem_rvalid) begin
      data_q   <= ext_data;
    end
  end

  load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .rdata       (mem_rdata),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ext_data    (ext_data)
  );

  assign mem_we    = mem_we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_data  = data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit instance driven from a vector
// table plus hand sequences, and a 64-bit instance for dword/upper-lane loads.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        a_req_valid = 0, a_req_we = 0, a_req_unsigned = 0;
  logic [1:0]  a_req_size = 0;
  logic [31:0] a_req_addr = 0, a_req_wdata = 0;
  logic        a_req_ready, a_mem_valid, a_mem_we, a_rsp_valid, a_rsp_exc;
  logic        a_mem_ready = 0, a_mem_rvalid = 0;
  logic [3:0]  a_mem_be;
  logic [31:0] a_mem_addr, a_mem_wdata, a_rsp_data;
  logic [31:0] a_mem_rdata = 0;

  // 64-bit instance signals
  logic        b_req_valid = 0, b_req_we = 0, b_req_unsigned = 0;
  logic [1:0]  b_req_size = 0;
  logic [31:0] b_req_addr = 0;
  logic [63:0] b_req_wdata = 0;
  logic        b_req_ready, b_mem_valid, b_mem_we, b_rsp_valid, b_rsp_exc;
  logic        b_mem_ready = 0, b_mem_rvalid = 0;
  logic [7:0]  b_mem_be;
  logic [31:0] b_mem_addr;
  logic [63:0] b_mem_wdata, b_rsp_data;
  logic [63:0] b_mem_rdata = 0;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_size(a_req_size), .req_unsigned(a_req_unsigned), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .mem_valid(a_mem_valid), .mem_ready(a_mem_ready),
    .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rvalid(a_mem_rvalid), .mem_rdata(a_mem_rdata), .rsp_valid(a_rsp_valid),
    .rsp_data(a_rsp_data), .rsp_exc(a_rsp_exc)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .mem_valid(b_mem_valid), .mem_ready(b_mem_ready),
    .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata), .rsp_valid(b_rsp_valid),
    .rsp_data(b_rsp_data), .rsp_exc(b_rsp_exc)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exc;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] rsp;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  // One transaction on the 32-bit unit, starting #1 after an edge in IDLE.
  task automatic run32(input int idx, input vec_t v);
    a_req_valid = 1'b1; a_req_we = v.we; a_req_size = v.size;
    a_req_unsigned = v.uns; a_req_addr = v.addr; a_req_wdata = v.wdata;
    chk($sformatf("v%0d.req_ready", idx), 64'(a_req_ready), 64'd1);
    @(posedge clk); #1;
    // Scramble request inputs to prove they were registered on accept.
    a_req_valid = 1'b0; a_req_addr = 32'hFFFF_FFFF; a_req_wdata = $urandom;
    a_req_size = 2'd3; a_req_we = ~v.we; a_req_unsigned = ~v.uns;
    if (v.exc) begin
      chk($sformatf("v%0d.exc_valid", idx), 64'(a_rsp_valid), 64'd1);
      chk($sformatf("v%0d.exc_flag", idx), 64'(a_rsp_exc), 64'd1);
      chk($sformatf("v%0d.exc_memvalid", idx), 64'(a_mem_valid), 64'd0);
      chk($sformatf("v%0d.exc_data", idx), 64'(a_rsp_data), 64'd0);
    end else begin
      chk($sformatf("v%0d.mem_valid", idx), 64'(a_mem_valid), 64'd1);
      chk($sformatf("v%0d.mem_we", idx), 64'(a_mem_we), 64'(v.we));
      chk($sformatf("v%0d.mem_be", idx), 64'(a_mem_be), 64'(v.be));
      chk($sformatf("v%0d.mem_addr", idx), 64'(a_mem_addr), 64'(v.maddr));
      if (v.we) chk($sformatf("v%0d.mem_wdata", idx), 64'(a_mem_wdata), 64'(v.mwdata));
      a_mem_ready = 1'b1;
      @(posedge clk); #1;
      a_mem_ready = 1'b0;
      if (!v.we) begin
        chk($sformatf("v%0d.wait_memvalid", idx), 64'(a_mem_valid), 64'd0);
        chk($sformatf("v%0d.wait_rsp", idx), 64'(a_rsp_valid), 64'd0);
        a_mem_rvalid = 1'b1; a_mem_rdata = v.rdata;
        @(posedge clk); #1;
        a_mem_rvalid = 1'b0; a_mem_rdata = $urandom;
      end
      chk($sformatf("v%0d.rsp_valid", idx), 64'(a_rsp_valid), 64'd1);
      chk($sformatf("v%0d.rsp_exc", idx), 64'(a_rsp_exc), 64'd0);
      chk($sformatf("v%0d.rsp_data", idx), 64'(a_rsp_data), 64'(v.rsp));
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d.rsp_pulse_end", idx), 64'(a_rsp_valid), 64'd0);
    chk($sformatf("v%0d.back_idle", idx), 64'(a_req_ready), 64'd1);
  endtask

  // One load on the 64-bit unit, minimum-latency handshakes.
  task automatic load64(input string nm, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [63:0] rdata,
                        input logic [7:0] be, input logic [31:0] maddr,
                        input logic [63:0] rsp);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_size = size;
    b_req_unsigned = uns; b_req_addr = addr;
    @(posedge clk); #1;
    b_req_valid = 1'b0; b_req_addr = 32'hFFFF_FFFF;
    chk({nm, ".mem_valid"}, 64'(b_mem_valid), 64'd1);
    chk({nm, ".mem_be"}, 64'(b_mem_be), 64'(be));
    chk({nm, ".mem_addr"}, 64'(b_mem_addr), 64'(maddr));
    b_mem_ready = 1'b1;
    @(posedge clk); #1;
    b_mem_ready = 1'b0; b_mem_rvalid = 1'b1; b_mem_rdata = rdata;
    @(posedge clk); #1;
    b_mem_rvalid = 1'b0; b_mem_rdata = '0;
    chk({nm, ".rsp_valid"}, 64'(b_rsp_valid), 64'd1);
    chk({nm, ".rsp_exc"}, 64'(b_rsp_exc), 64'd0);
    chk({nm, ".rsp_data"}, b_rsp_data, rsp);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80FF_0000, 1'b0, 4'b1000,
                 32'h1000, 32'h0, 32'hFFFF_FF80};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80FF_0000, 1'b0, 4'b1000,
                 32'h1000, 32'h0, 32'h0000_0080};
    vecs[2]  = '{1'b1, 2'd1, 1'b0, 32'h2002, 32'h1234_BEEF, 32'h0, 1'b0, 4'b1100,
                 32'h2000, 32'hBEEF_BEEF, 32'h0};
    vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h0002, 32'h0, 32'h8001_7FFF, 1'b0, 4'b1100,
                 32'h0000, 32'h0, 32'hFFFF_8001};
    vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h0004, 32'h0, 32'h1234_ABCD, 1'b0, 4'b0011,
                 32'h0004, 32'h0, 32'h0000_ABCD};
    vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 4'b1111,
                 32'h0008, 32'h0, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, 2'd0, 1'b0, 32'h0011, 32'hFFFF_FFA5, 32'h0, 1'b0, 4'b0010,
                 32'h0010, 32'hA5A5_A5A5, 32'h0};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 32'h0020, 32'h1234_5678, 32'h0, 1'b0, 4'b1111,
                 32'h0020, 32'h1234_5678, 32'h0};
    vecs[8]  = '{1'b0, 2'd3, 1'b0, 32'h0000, 32'h0, 32'h0, 1'b1, 4'b0000,
                 32'h0, 32'h0, 32'h0};
`ifdef MEM_ACCESS_ALIGN_EXC_EN
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h3002, 32'h0, 32'hCAFE_F00D, 1'b1, 4'b0000,
                 32'h0, 32'h0, 32'h0};
`else
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h3002, 32'h0, 32'hCAFE_F00D, 1'b0, 4'b1111,
                 32'h3000, 32'h0, 32'hCAFE_F00D};
`endif
    vecs[10] = '{1'b0, 2'd0, 1'b0, 32'h1001, 32'h0, 32'h0000_7F00, 1'b0, 4'b0010,
                 32'h1000, 32'h0, 32'h0000_007F};

    // Reset values while reset_n is low.
    #2;
    chk("rst.req_ready", 64'(a_req_ready), 64'd1);
    chk("rst.mem_valid", 64'(a_mem_valid), 64'd0);
    chk("rst.mem_we", 64'(a_mem_we), 64'd0);
    chk("rst.mem_be", 64'(a_mem_be), 64'd0);
    chk("rst.mem_addr", 64'(a_mem_addr), 64'd0);
    chk("rst.mem_wdata", 64'(a_mem_wdata), 64'd0);
    chk("rst.rsp_valid", 64'(a_rsp_valid), 64'd0);
    chk("rst.rsp_data", 64'(a_rsp_data), 64'd0);
    chk("rst.rsp_exc", 64'(a_rsp_exc), 64'd0);
    chk("rst64.mem_be", 64'(b_mem_be), 64'd0);
    chk("rst64.rsp_data", b_rsp_data, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) run32(i, vecs[i]);

    // Backpressure: mem_ready low for 5 cycles on a store.
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_size = 2'd2; a_req_unsigned = 1'b0;
    a_req_addr = 32'h0000_0040; a_req_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    a_req_valid = 1'b0; a_req_addr = 32'h0; a_req_wdata = 32'h0;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("bp%0d.mem_valid", c), 64'(a_mem_valid), 64'd1);
      chk($sformatf("bp%0d.req_ready", c), 64'(a_req_ready), 64'd0);
      chk($sformatf("bp%0d.mem_be", c), 64'(a_mem_be), 64'hF);
      chk($sformatf("bp%0d.mem_addr", c), 64'(a_mem_addr), 64'h40);
      chk($sformatf("bp%0d.mem_wdata", c), 64'(a_mem_wdata), 64'h1122_3344);
      chk($sformatf("bp%0d.rsp_valid", c), 64'(a_rsp_valid), 64'd0);
      if (c == 5) a_mem_ready = 1'b1;
      @(posedge clk); #1;
    end
    a_mem_ready = 1'b0;
    chk("bp.rsp_valid", 64'(a_rsp_valid), 64'd1);
    @(posedge clk); #1;

    // 64-bit bus: dword load passes through, upper-lane word sign-extends.
    load64("d64", 2'd3, 1'b0, 32'h08, 64'h8000_0000_0000_0001, 8'hFF, 32'h08,
           64'h8000_0000_0000_0001);
    load64("w64", 2'd2, 1'b0, 32'h0C, 64'h8765_4321_0000_0000, 8'hF0, 32'h08,
           64'hFFFF_FFFF_8765_4321);

    // Reset pulsed while a load waits for read data; stray rvalid afterwards.
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_size = 2'd2; a_req_addr = 32'h50;
    @(posedge clk); #1;
    a_req_valid = 1'b0; a_mem_ready = 1'b1;
    @(posedge clk); #1;
    a_mem_ready = 1'b0;
    chk("rw.in_wait", 64'(a_req_ready), 64'd0);
    reset_n = 1'b0;
    #1;
    chk("rw.mem_valid", 64'(a_mem_valid), 64'd0);
    chk("rw.req_ready", 64'(a_req_ready), 64'd1);
    chk("rw.mem_addr", 64'(a_mem_addr), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    a_mem_rvalid = 1'b1; a_mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    a_mem_rvalid = 1'b0;
    chk("rw.stray_rsp0", 64'(a_rsp_valid), 64'd0);
    @(posedge clk); #1;
    chk("rw.stray_rsp1", 64'(a_rsp_valid), 64'd0);
    chk("rw.stray_data", 64'(a_rsp_data), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
